// File: rtl/stream_concatenator.sv
// Merges two ready/valid streams into one frame: exactly NUM_ELEMENTS_FIRST_INPUT
// beats from A, then B beats up to and including B's last. The output sits in a
// one-entry registered buffer that sustains one beat per cycle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   ds_in_a/_valid/_last      stream A (last is checked only, never forwarded)
//   ds_in_a_next_data         ready to A (combinational)
//   ds_in_b/_valid/_last      stream B (last ends the frame)
//   ds_in_b_next_data         ready to B (combinational)
//   ds_out/_valid/_last       merged stream (registered)
//   ds_out_next_data          ready from sink
//   err_a_last                sticky flag: A last seen on the wrong element
module stream_concatenator #(
  parameter int unsigned WIDTH                    = 5,
  parameter int unsigned NUM_ELEMENTS_FIRST_INPUT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ds_in_a,
  input  logic             ds_in_a_valid,
  input  logic             ds_in_a_last,
  output logic             ds_in_a_next_data,
  input  logic [WIDTH-1:0] ds_in_b,
  input  logic             ds_in_b_valid,
  input  logic             ds_in_b_last,
  output logic             ds_in_b_next_data,
  output logic [WIDTH-1:0] ds_out,
  output logic             ds_out_valid,
  output logic             ds_out_last,
  input  logic             ds_out_next_data,
  output logic             err_a_last
);

  localparam int unsigned N     = NUM_ELEMENTS_FIRST_INPUT;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    S_A = 1'b0,
    S_B = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  logic               space_c;
  logic               acc_a_c;
  logic               acc_b_c;
  logic               cnt_at_last_c;

  // Buffer can take a beat when empty or when the sink drains it this cycle.
  assign space_c           = !valid_q || ds_out_next_data;
  assign ds_in_a_next_data = (state_q == S_A) && space_c;
  assign ds_in_b_next_data = (state_q == S_B) && space_c;
  assign acc_a_c           = ds_in_a_valid && ds_in_a_next_data;
  assign acc_b_c           = ds_in_b_valid && ds_in_b_next_data;
  assign cnt_at_last_c     = (cnt_q == CNT_LAST);

  // Next-state: routing FSM, element counter, output buffer and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;

    if (acc_a_c) begin
      data_d  = ds_in_a;
      valid_d = 1'b1;
      last_d  = 1'b0;
      // Error is recorded only; the switch to B still happens on count.
      if (ds_in_a_last != cnt_at_last_c) begin
        err_d = 1'b1;
      end
      if (cnt_at_last_c) begin
        cnt_d   = '0;
        state_d = S_B;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (acc_b_c) begin
      data_d  = ds_in_b;
      valid_d = 1'b1;
      last_d  = ds_in_b_last;
      if (ds_in_b_last) begin
        state_d = S_A;
      end
    end else if (ds_out_next_data) begin
      // Drained with nothing new behind it; data/last keep their stale value.
      valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_A;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign ds_out       = data_q;
  assign ds_out_valid = valid_q;
  assign ds_out_last  = last_q;
  assign err_a_last   = err_q;

endmodule

// File: tb/tb_stream_concatenator.sv
// Randomized bench for stream_concatenator. Frames are described as plain lists
// (N A-elements followed by a variable number of B-elements); the expected output
// is simply that concatenation, checked beat by beat with stall/phase/error rules.
module tb_stream_concatenator;

  localparam int W = 5;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ds_in_a;
  logic         ds_in_a_valid;
  logic         ds_in_a_last;
  logic         ds_in_a_next_data;
  logic [W-1:0] ds_in_b;
  logic         ds_in_b_valid;
  logic         ds_in_b_last;
  logic         ds_in_b_next_data;
  logic [W-1:0] ds_out;
  logic         ds_out_valid;
  logic         ds_out_last;
  logic         ds_out_next_data;
  logic         err_a_last;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [W-1:0] a_data[$];
  bit           a_last[$];
  logic [W-1:0] b_data[$];
  bit           b_last[$];
  logic [W-1:0] exp_data[$];
  bit           exp_last[$];
  int           a_taken;
  bit           err_exp;

  stream_concatenator #(
    .WIDTH                    (W),
    .NUM_ELEMENTS_FIRST_INPUT (N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ds_in_a           (ds_in_a),
    .ds_in_a_valid     (ds_in_a_valid),
    .ds_in_a_last      (ds_in_a_last),
    .ds_in_a_next_data (ds_in_a_next_data),
    .ds_in_b           (ds_in_b),
    .ds_in_b_valid     (ds_in_b_valid),
    .ds_in_b_last      (ds_in_b_last),
    .ds_in_b_next_data (ds_in_b_next_data),
    .ds_out            (ds_out),
    .ds_out_valid      (ds_out_valid),
    .ds_out_last       (ds_out_last),
    .ds_out_next_data  (ds_out_next_data),
    .err_a_last        (err_a_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Append one frame: N A-elements (last flag on bad_pos), then nb B-elements.
  task automatic add_frame(input bit rnd, input int nb, input int bad_pos);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = rnd ? W'($urandom) : W'(i);
      a_data.push_back(v);
      a_last.push_back(i == bad_pos);
      exp_data.push_back(v);
      exp_last.push_back(1'b0);
    end
    for (int j = 0; j < nb; j++) begin
      v = rnd ? W'($urandom) : W'(N + j);
      b_data.push_back(v);
      b_last.push_back(j == nb - 1);
      exp_data.push_back(v);
      exp_last.push_back(j == nb - 1);
    end
  endtask

  task automatic idle_inputs();
    ds_in_a_valid    = 1'b0;
    ds_in_a          = '0;
    ds_in_a_last     = 1'b0;
    ds_in_b_valid    = 1'b0;
    ds_in_b          = '0;
    ds_in_b_last     = 1'b0;
    ds_out_next_data = 1'b0;
  endtask

  task automatic model_reset();
    a_data.delete();
    a_last.delete();
    b_data.delete();
    b_last.delete();
    exp_data.delete();
    exp_last.delete();
    a_taken = 0;
    err_exp = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(ds_out_valid), 32'd0);
    check_eq({tag, "_data"},  32'(ds_out),       32'd0);
    check_eq({tag, "_last"},  32'(ds_out_last),  32'd0);
    check_eq({tag, "_err"},   32'(err_a_last),   32'd0);
  endtask

  // p_a/p_b: valid probability in percent (-1 on A = valid every other cycle).
  // sink_mode: 0 always ready, 1 ready one cycle in three, 2 random.
  // stop_in_b: return as soon as the DUT is routing B with a full buffer.
  task automatic run(input int p_a, input int p_b, input int sink_mode, input bit stop_in_b);
    int           cyc = 0;
    bit           hs_a = 0, hs_b = 0, hs_o = 0;
    bit           prev_stall = 0;
    logic [W-1:0] snap_d = '0;
    bit           snap_l = 0;
    bit           stopped = 0;
    while (exp_data.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      // Account for the transfers that happened on the edge just passed.
      if (hs_a) begin
        check_eq("a_in_phase_a", 32'(a_taken < N), 32'd1);
        if (a_last[0] != (a_taken == N - 1)) err_exp = 1'b1;
        a_taken++;
        void'(a_data.pop_front());
        void'(a_last.pop_front());
      end
      if (hs_b) begin
        check_eq("b_after_n_a", 32'(a_taken), 32'(N));
        if (b_last[0]) a_taken = 0;
        void'(b_data.pop_front());
        void'(b_last.pop_front());
      end
      if (hs_o) begin
        check_eq("out_data", 32'(snap_d), 32'(exp_data[0]));
        check_eq("out_last", 32'(snap_l), 32'(exp_last[0]));
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
      end
      check_eq("err_a_last", 32'(err_a_last), 32'(err_exp));
      if (prev_stall) begin
        check_eq("stall_valid", 32'(ds_out_valid), 32'd1);
        check_eq("stall_data",  32'(ds_out),       32'(snap_d));
        check_eq("stall_last",  32'(ds_out_last),  32'(snap_l));
      end
      if (exp_data.size() == 0) break;

      // Drive the next cycle.
      if (a_data.size() > 0 && (p_a < 0 ? cyc[0] : ($urandom_range(0, 99) < p_a))) begin
        ds_in_a_valid = 1'b1;
        ds_in_a       = a_data[0];
        ds_in_a_last  = a_last[0];
      end else begin
        ds_in_a_valid = 1'b0;
        ds_in_a       = W'($urandom);
        ds_in_a_last  = 1'($urandom);
      end
      if (b_data.size() > 0 && $urandom_range(0, 99) < p_b) begin
        ds_in_b_valid = 1'b1;
        ds_in_b       = b_data[0];
        ds_in_b_last  = b_last[0];
      end else begin
        ds_in_b_valid = 1'b0;
        ds_in_b       = W'($urandom);
        ds_in_b_last  = 1'($urandom);
      end
      case (sink_mode)
        0:       ds_out_next_data = 1'b1;
        1:       ds_out_next_data = (cyc % 3 == 0);
        default: ds_out_next_data = 1'($urandom);
      endcase
      #1;
      // Only the input whose turn it is may be offered ready.
      if (a_taken < N) check_eq("b_ready_in_a", 32'(ds_in_b_next_data), 32'd0);
      else             check_eq("a_ready_in_b", 32'(ds_in_a_next_data), 32'd0);
      hs_a       = ds_in_a_valid && ds_in_a_next_data;
      hs_b       = ds_in_b_valid && ds_in_b_next_data;
      hs_o       = ds_out_valid && ds_out_next_data;
      prev_stall = ds_out_valid && !ds_out_next_data;
      snap_d     = ds_out;
      snap_l     = ds_out_last;
      if (stop_in_b && a_taken == N && ds_out_valid) begin
        stopped = 1'b1;
        break;
      end
    end
    if (!stopped) begin
      check_eq("frames_done", 32'(exp_data.size()), 32'd0);
      @(negedge clk);
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: one frame, A=0..4, B=5,6,7, sink always ready.
    add_frame(1'b0, 3, N - 1);
    run(100, 100, 0, 1'b0);

    // 2: B always valid, A every other cycle.
    add_frame(1'b0, 3, N - 1);
    run(-1, 100, 0, 1'b0);

    // 3: sink ready one cycle in three.
    add_frame(1'b0, 3, N - 1);
    run(100, 100, 1, 1'b0);

    // 4: two back-to-back frames with a single B element.
    add_frame(1'b0, 1, N - 1);
    add_frame(1'b0, 1, N - 1);
    run(100, 100, 0, 1'b0);

    // Random frames, random valids and sink backpressure.
    for (int k = 0; k < 20; k++) begin
      add_frame(1'b1, $urandom_range(1, 4), N - 1);
    end
    run(70, 60, 2, 1'b0);

    // 5: A last on element 2; error sticks, routing unchanged.
    add_frame(1'b0, 3, 2);
    add_frame(1'b1, 2, N - 1);
    run(100, 100, 2, 1'b0);
    check_eq("err_sticky", 32'(err_a_last), 32'd1);

    // 6: asynchronous reset while routing B with a full buffer.
    add_frame(1'b0, 3, N - 1);
    run(100, 100, 0, 1'b1);
    check_eq("in_b_before_rst", 32'(ds_in_b_next_data), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check_eq("rst_a_ready", 32'(ds_in_a_next_data), 32'd0 | 32'(!ds_out_valid));
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    add_frame(1'b0, 3, N - 1);
    run(100, 100, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
